// File: rtl/uart_program_loader.sv
// Frame-based program loader: SYNC, LEN, LEN data bytes, checksum. Each data byte is
// written to program memory as two nibbles (low first) while the CPU is held in reset.
module uart_program_loader #(
  parameter int                          UART_DATA_LENGTH  = 8,
  parameter int                          MEM_ADDR_BITWIDTH = 8,
  parameter logic [UART_DATA_LENGTH-1:0] SYNC_BYTE         = 8'hA5,
  parameter int                          TIMEOUT_COUNTS    = 1_000_000,
  parameter int                          TIMEOUT_BITWIDTH  = 20
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [UART_DATA_LENGTH-1:0]  data_i,
  input  logic                         data_valid_strb_i,
  output logic                         mem_we_o,
  output logic [MEM_ADDR_BITWIDTH-1:0] mem_addr_o,
  output logic [3:0]                   mem_data_o,
  output logic                         cpu_hold_o,
  output logic                         load_done_o,
  output logic                         load_error_o
);

  // Largest LEN whose nibbles fit in the address space, clipped to what data_i can carry.
  localparam int MAX_LEN_INT = (MEM_ADDR_BITWIDTH - 1 >= UART_DATA_LENGTH) ?
                               (2 ** UART_DATA_LENGTH) - 1 : 2 ** (MEM_ADDR_BITWIDTH - 1);
  localparam logic [UART_DATA_LENGTH:0]   MAX_LEN      = (UART_DATA_LENGTH + 1)'(MAX_LEN_INT);
  localparam logic [TIMEOUT_BITWIDTH-1:0] TIMEOUT_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_COUNTS - 1);

  typedef enum logic [2:0] {
    stIDLE     = 3'd0,
    stLENGTH   = 3'd1,
    stDATA     = 3'd2,
    stWRITE_LO = 3'd3,
    stWRITE_HI = 3'd4,
    stCHECKSUM = 3'd5,
    stDONE     = 3'd6,
    stERROR    = 3'd7
  } state_t;

  state_t                        state_r;
  logic [MEM_ADDR_BITWIDTH-1:0]  addr_r;
  logic [UART_DATA_LENGTH-1:0]   len_r;
  logic [UART_DATA_LENGTH-1:0]   byte_cnt_r;
  logic [UART_DATA_LENGTH-1:0]   csum_r;
  logic [UART_DATA_LENGTH-1:0]   hold_r;
  logic [TIMEOUT_BITWIDTH-1:0]   timeout_r;
  logic                          overrun_r;

  // Frame parser, nibble writer and inter-byte timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= stIDLE;
      addr_r     <= '0;
      len_r      <= '0;
      byte_cnt_r <= '0;
      csum_r     <= '0;
      hold_r     <= '0;
      timeout_r  <= '0;
      overrun_r  <= 1'b0;
    end else begin
      case (state_r)
        stIDLE, stDONE, stERROR: begin
          if (data_valid_strb_i && (data_i == SYNC_BYTE)) begin
            state_r    <= stLENGTH;
            addr_r     <= '0;
            csum_r     <= '0;
            byte_cnt_r <= '0;
            timeout_r  <= '0;
            overrun_r  <= 1'b0;
          end
        end
        stLENGTH: begin
          if (data_valid_strb_i) begin
            len_r     <= data_i;
            timeout_r <= '0;
            if ((data_i != '0) && ({1'b0, data_i} <= MAX_LEN)) state_r <= stDATA;
            else                                                  state_r <= stERROR;
          end else if (timeout_r == TIMEOUT_LAST) begin
            state_r   <= stERROR;
            timeout_r <= '0;
          end else begin
            timeout_r <= timeout_r + TIMEOUT_BITWIDTH'(1);
          end
        end
        stDATA: begin
          if (data_valid_strb_i) begin
            hold_r    <= data_i;
            csum_r    <= csum_r + data_i;
            timeout_r <= '0;
            state_r   <= stWRITE_LO;
          end else if (timeout_r == TIMEOUT_LAST) begin
            state_r   <= stERROR;
            timeout_r <= '0;
          end else begin
            timeout_r <= timeout_r + TIMEOUT_BITWIDTH'(1);
          end
        end
        stWRITE_LO: begin
          // An early strobe is remembered so the high nibble still lands before the error.
          addr_r <= addr_r + MEM_ADDR_BITWIDTH'(1);
          if (data_valid_strb_i) overrun_r <= 1'b1;
          state_r <= stWRITE_HI;
        end
        stWRITE_HI: begin
          addr_r     <= addr_r + MEM_ADDR_BITWIDTH'(1);
          byte_cnt_r <= byte_cnt_r + UART_DATA_LENGTH'(1);
          if (data_valid_strb_i || overrun_r)                         state_r <= stERROR;
          else if ((byte_cnt_r + UART_DATA_LENGTH'(1)) == len_r)      state_r <= stCHECKSUM;
          else                                                        state_r <= stDATA;
        end
        stCHECKSUM: begin
          if (data_valid_strb_i) begin
            timeout_r <= '0;
            state_r   <= (data_i == csum_r) ? stDONE : stERROR;
          end else if (timeout_r == TIMEOUT_LAST) begin
            state_r   <= stERROR;
            timeout_r <= '0;
          end else begin
            timeout_r <= timeout_r + TIMEOUT_BITWIDTH'(1);
          end
        end
        default: state_r <= stIDLE;
      endcase
    end
  end

  // Moore outputs, decoded straight from the state and address flops.
  assign mem_we_o     = (state_r == stWRITE_LO) || (state_r == stWRITE_HI);
  assign mem_addr_o   = addr_r;
  assign mem_data_o   = (state_r == stWRITE_LO) ? hold_r[3:0] :
                        (state_r == stWRITE_HI) ? hold_r[7:4] : 4'h0;
  assign cpu_hold_o   = (state_r != stIDLE) && (state_r != stDONE);
  assign load_done_o  = (state_r == stDONE);
  assign load_error_o = (state_r == stERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: a frame-level model predicts the nibble writes
// and final status; a per-cycle compare process checks every memory write against it.
module tb_uart_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       strb;
  logic       mem_we_o;
  logic [7:0] mem_addr_o;
  logic [3:0] mem_data_o;
  logic       cpu_hold_o;
  logic       load_done_o;
  logic       load_error_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [3:0] nib;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frm[$];
  wr_t        cur_w;
  logic       pd, pe;

  uart_program_loader #(
    .UART_DATA_LENGTH (8),
    .MEM_ADDR_BITWIDTH(8),
    .SYNC_BYTE        (8'hA5),
    .TIMEOUT_COUNTS   (50),
    .TIMEOUT_BITWIDTH (20)
  ) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .data_i           (data),
    .data_valid_strb_i(strb),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .cpu_hold_o       (cpu_hold_o),
    .load_done_o      (load_done_o),
    .load_error_o     (load_error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (!rst && mem_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, mem_addr_o, mem_data_o}, 32'hFFFF_FFFF);
      end else begin
        cur_w = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr_o), 32'(cur_w.addr));
        check("wr_data", 32'(mem_data_o), 32'(cur_w.nib));
        check("wr_hold", 32'(cpu_hold_o), 32'd1);
      end
    end
  end

  // Frame-level model: nibble writes in address order, checksum is byte sum mod 256.
  task automatic predict(output logic done, output logic err);
    int         len;
    logic [7:0] sum;
    done = 1'b0;
    err  = 1'b0;
    sum  = 8'd0;
    if (frm.size() < 2) return;
    len = int'(frm[1]);
    if (len < 1 || len > 128) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < len && 2 + i < frm.size(); i++) begin
      exp_q.push_back('{addr: 8'(2 * i),     nib: frm[2 + i][3:0]});
      exp_q.push_back('{addr: 8'(2 * i + 1), nib: frm[2 + i][7:4]});
      sum = sum + frm[2 + i];
    end
    if (frm.size() > 2 + len) begin
      done = (frm[2 + len] == sum);
      err  = !done;
    end
  endtask

  task automatic send_now(input logic [7:0] b);
    data = b;
    strb = 1'b1;
    @(posedge clk);
    #1;
    strb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (4) @(posedge clk);
    #1;
    send_now(b);
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic settle(input string name, input logic done, input logic err, input logic hold);
    repeat (4) @(negedge clk);
    check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done"},    32'(load_done_o),  32'(done));
    check({name, "_error"},   32'(load_error_o), 32'(err));
    check({name, "_hold"},    32'(cpu_hold_o),   32'(hold));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_we"},   32'(mem_we_o),     32'd0);
    check({name, "_addr"}, 32'(mem_addr_o),   32'd0);
    check({name, "_data"}, 32'(mem_data_o),   32'd0);
    check({name, "_hold"}, 32'(cpu_hold_o),   32'd0);
    check({name, "_done"}, 32'(load_done_o),  32'd0);
    check({name, "_err"},  32'(load_error_o), 32'd0);
  endtask

  initial begin
    rst  = 1'b0;
    data = 8'h00;
    strb = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Good two-byte frame; checksum 3C+F1 = 12D -> 2D.
    frm = '{8'hA5, 8'h02, 8'h3C, 8'hF1, 8'h2D};
    predict(pd, pe);
    check("model_nwr", 32'(exp_q.size()), 32'd4);
    check("model_wr0", 32'(exp_q[0]), 32'h00C);
    check("model_wr3", 32'(exp_q[3]), 32'h03F);
    check("model_done", 32'(pd), 32'd1);
    send_frame();
    settle("good", pd, pe, 1'b0);

    // Bad checksum: 10 sums to 10, 11 received.
    frm = '{8'hA5, 8'h01, 8'h10, 8'h11};
    predict(pd, pe);
    check("model_bad_err", 32'(pe), 32'd1);
    send_frame();
    settle("badsum", pd, pe, 1'b1);

    // Length out of range at both ends, then recovery.
    frm = '{8'hA5, 8'h00};
    predict(pd, pe);
    send_frame();
    settle("len00", pd, pe, 1'b1);
    frm = '{8'hA5, 8'h81};
    predict(pd, pe);
    send_frame();
    settle("len81", pd, pe, 1'b1);
    frm = '{8'hA5, 8'h01, 8'h07, 8'h07};
    predict(pd, pe);
    send_frame();
    settle("recover", pd, pe, 1'b0);

    // Stalled frame: error exactly 50 clocks after the 3C write finishes.
    frm = '{8'hA5, 8'h02, 8'h3C};
    predict(pd, pe);
    send_frame();
    repeat (52) @(negedge clk);
    check("timeout_early", 32'(load_error_o), 32'd0);
    @(negedge clk);
    check("timeout_hit", 32'(load_error_o), 32'd1);
    settle("timeout", 1'b0, 1'b1, 1'b1);

    // Strobe one cycle after a data strobe: both nibbles written, then error.
    frm = '{8'hA5, 8'h01, 8'h3C};
    predict(pd, pe);
    send_frame();
    send_now(8'h55);
    settle("overrun", 1'b0, 1'b1, 1'b1);

    // Reset during the second data byte, then a stray byte with no sync.
    frm = '{8'hA5, 8'h02, 8'h3C};
    predict(pd, pe);
    send_frame();
    send_byte(8'hF1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_byte(8'h3C);
    settle("stray", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
